// File: rtl/fifo_key_ctrl.sv
// fifo_key_ctrl
// Front-end controller for the lab FIFO. Turns raw push/pop key levels into
// single-cycle strobes, registers the write data, gates strobes with the
// FIFO full/empty flags, records illegal attempts and tracks occupancy.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   push_key     raw push key level (asynchronous)
//   pop_key      raw pop key level (asynchronous)
//   data_in      value to enqueue, sampled when a push issues
//   empty, full  FIFO status flags
//   fifo_data    FIFO read data, valid the cycle after pop
//   push, pop    registered single-cycle strobes to the FIFO
//   pushedValue  registered write data, valid while push=1
//   shown_value  last value popped; shown_valid once any value was captured
//   count        occupancy as tracked by issued strobes
//   overflow     sticky: push request while full
//   underflow    sticky: pop request while empty
//
// Pop FSM:
//   state  | meaning
//   S_IDLE | ready to accept a pop request
//   S_WAIT | pop issued; waiting for fifo_data and capturing it
module fifo_key_ctrl #(
    parameter int depth = 4,
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_key,
    input  logic             pop_key,
    input  logic [width-1:0] data_in,
    input  logic             empty,
    input  logic             full,
    input  logic [width-1:0] fifo_data,
    output logic             push,
    output logic             pop,
    output logic [width-1:0] pushedValue,
    output logic [width-1:0] shown_value,
    output logic             shown_valid,
    output logic [depth:0]   count,
    output logic             overflow,
    output logic             underflow
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [depth:0] COUNT_ONE = 1;

    state_t         state;
    state_t         state_next;

    logic           push_s1;
    logic           push_s2;
    logic           push_prev;
    logic           pop_s1;
    logic           pop_s2;
    logic           pop_prev;

    logic           push_req;
    logic           pop_req;
    logic           push_issue;
    logic           pop_issue;
    logic           underflow_set;
    logic           capture;
    logic [depth:0] count_next;

    assign push_req   = push_s2 & ~push_prev;
    assign pop_req    = pop_s2 & ~pop_prev;
    assign push_issue = push_req & ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // WAIT spans two cycles: the cycle pop is high (FIFO not yet read) and
    // the following cycle, where fifo_data is valid and gets captured.
    // The registered pop strobe tells the two apart.
    always_comb begin
        state_next    = state;
        pop_issue     = 1'b0;
        underflow_set = 1'b0;
        capture       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop_req) begin
                    if (!empty) begin
                        pop_issue  = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        underflow_set = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!pop) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push_issue, pop_issue})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_s1     <= 1'b0;
            push_s2     <= 1'b0;
            push_prev   <= 1'b0;
            pop_s1      <= 1'b0;
            pop_s2      <= 1'b0;
            pop_prev    <= 1'b0;
            push        <= 1'b0;
            pop         <= 1'b0;
            pushedValue <= '0;
            shown_value <= '0;
            shown_valid <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            push_s1   <= push_key;
            push_s2   <= push_s1;
            push_prev <= push_s2;
            pop_s1    <= pop_key;
            pop_s2    <= pop_s1;
            pop_prev  <= pop_s2;

            push  <= push_issue;
            pop   <= pop_issue;
            count <= count_next;

            if (push_issue) begin
                pushedValue <= data_in;
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end
            if (underflow_set) begin
                underflow <= 1'b1;
            end
            if (capture) begin
                shown_value <= fifo_data;
                shown_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_key_ctrl.sv
module tb_fifo_key_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       push_key;
    logic       pop_key;
    logic [7:0] data_in;
    logic       empty;
    logic       full;
    logic [7:0] fifo_data;
    logic       push;
    logic       pop;
    logic [7:0] pushedValue;
    logic [7:0] shown_value;
    logic       shown_valid;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_key_ctrl #(.depth(4), .width(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_key    (push_key),
        .pop_key     (pop_key),
        .data_in     (data_in),
        .empty       (empty),
        .full        (full),
        .fifo_data   (fifo_data),
        .push        (push),
        .pop         (pop),
        .pushedValue (pushedValue),
        .shown_value (shown_value),
        .shown_valid (shown_valid),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        logic       pk;
        logic       ok;
        logic [7:0] din;
        logic       emp;
        logic       ful;
        logic [7:0] fd;
        logic       e_push;
        logic       e_pop;
        logic [7:0] e_pv;
        logic [4:0] e_cnt;
        logic       e_ovf;
        logic       e_unf;
        logic       e_svv;
        logic [7:0] e_sv;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic pk, input logic ok, input logic [7:0] din,
                                input logic emp, input logic ful, input logic [7:0] fd,
                                input logic e_push, input logic e_pop, input logic [7:0] e_pv,
                                input logic [4:0] e_cnt, input logic e_ovf, input logic e_unf,
                                input logic e_svv, input logic [7:0] e_sv);
        vec_t v;
        v.pk = pk; v.ok = ok; v.din = din; v.emp = emp; v.ful = ful; v.fd = fd;
        v.e_push = e_push; v.e_pop = e_pop; v.e_pv = e_pv; v.e_cnt = e_cnt;
        v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_svv = e_svv; v.e_sv = e_sv;
        return v;
    endfunction

    task automatic step(input logic pk, input logic ok, input logic [7:0] din,
                        input logic emp, input logic ful, input logic [7:0] fd);
        push_key  = pk;
        pop_key   = ok;
        data_in   = din;
        empty     = emp;
        full      = ful;
        fifo_data = fd;
        @(posedge clk);
        #1;
    endtask

    // pushedValue is only compared while a push strobe is expected.
    task automatic check(input string name, input logic e_push, input logic e_pop,
                         input logic [7:0] e_pv, input logic [4:0] e_cnt, input logic e_ovf,
                         input logic e_unf, input logic e_svv, input logic [7:0] e_sv);
        logic [25:0] act;
        logic [25:0] exp;
        act = {push, pop, count, overflow, underflow, shown_valid, shown_value,
               (e_push ? pushedValue : 8'h00)};
        exp = {e_push, e_pop, e_cnt, e_ovf, e_unf, e_svv, e_sv, (e_push ? e_pv : 8'h00)};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got push=%b pop=%b cnt=%0d ovf=%b unf=%b svv=%b sv=%h pv=%h, expected push=%b pop=%b cnt=%0d ovf=%b unf=%b svv=%b sv=%h pv=%h",
                     name, push, pop, count, overflow, underflow, shown_valid, shown_value,
                     pushedValue, e_push, e_pop, e_cnt, e_ovf, e_unf, e_svv, e_sv, e_pv);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int pulses;

        //                pk ok din    emp ful fd     push pop pv     cnt ovf unf svv sv
        vecs[0]  = mk(1, 0, 8'h11, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        vecs[1]  = mk(0, 0, 8'h11, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        vecs[2]  = mk(0, 0, 8'h11, 0, 0, 8'h00, 1, 0, 8'h11, 1, 0, 0, 0, 8'h00);
        vecs[3]  = mk(1, 0, 8'h22, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[4]  = mk(0, 0, 8'h22, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[5]  = mk(0, 0, 8'h22, 0, 0, 8'h00, 1, 0, 8'h22, 2, 0, 0, 0, 8'h00);
        vecs[6]  = mk(1, 0, 8'h33, 0, 0, 8'h00, 0, 0, 8'h00, 2, 0, 0, 0, 8'h00);
        vecs[7]  = mk(0, 0, 8'h33, 0, 0, 8'h00, 0, 0, 8'h00, 2, 0, 0, 0, 8'h00);
        vecs[8]  = mk(0, 0, 8'h33, 0, 0, 8'h00, 1, 0, 8'h33, 3, 0, 0, 0, 8'h00);
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 3, 0, 0, 0, 8'h00);
        // push while full
        vecs[10] = mk(1, 0, 8'h77, 0, 1, 8'h00, 0, 0, 8'h00, 3, 0, 0, 0, 8'h00);
        vecs[11] = mk(0, 0, 8'h77, 0, 1, 8'h00, 0, 0, 8'h00, 3, 0, 0, 0, 8'h00);
        vecs[12] = mk(0, 0, 8'h77, 0, 1, 8'h00, 0, 0, 8'h00, 3, 1, 0, 0, 8'h00);
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 3, 1, 0, 0, 8'h00);
        // simultaneous push and pop, flags low
        vecs[14] = mk(1, 1, 8'h44, 0, 0, 8'h00, 0, 0, 8'h00, 3, 1, 0, 0, 8'h00);
        vecs[15] = mk(0, 0, 8'h44, 0, 0, 8'h00, 0, 0, 8'h00, 3, 1, 0, 0, 8'h00);
        vecs[16] = mk(0, 0, 8'h44, 0, 0, 8'h00, 1, 1, 8'h44, 3, 1, 0, 0, 8'h00);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 8'h00, 3, 1, 0, 0, 8'h00);
        vecs[18] = mk(0, 0, 8'h00, 0, 0, 8'h66, 0, 0, 8'h00, 3, 1, 0, 1, 8'h66);
        vecs[19] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 3, 1, 0, 1, 8'h66);
        // simultaneous push and pop while empty
        vecs[20] = mk(1, 1, 8'h55, 1, 0, 8'h00, 0, 0, 8'h00, 3, 1, 0, 1, 8'h66);
        vecs[21] = mk(0, 0, 8'h55, 1, 0, 8'h00, 0, 0, 8'h00, 3, 1, 0, 1, 8'h66);
        vecs[22] = mk(0, 0, 8'h55, 1, 0, 8'h00, 1, 0, 8'h55, 4, 1, 1, 1, 8'h66);
        vecs[23] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 4, 1, 1, 1, 8'h66);
        // plain pop, data arrives the cycle after the strobe
        vecs[24] = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 4, 1, 1, 1, 8'h66);
        vecs[25] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 4, 1, 1, 1, 8'h66);
        vecs[26] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 3, 1, 1, 1, 8'h66);
        vecs[27] = mk(0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 8'h00, 3, 1, 1, 1, 8'h66);
        vecs[28] = mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 8'h00, 3, 1, 1, 1, 8'hA5);
        vecs[29] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 3, 1, 1, 1, 8'hA5);

        // reset state with busy-looking inputs
        reset     = 1'b1;
        push_key  = 1'b0;
        pop_key   = 1'b0;
        data_in   = 8'hEE;
        empty     = 1'b0;
        full      = 1'b1;
        fifo_data = 8'hDD;
        #3;
        check("reset_state", 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        #9;
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            step(vecs[i].pk, vecs[i].ok, vecs[i].din, vecs[i].emp, vecs[i].ful, vecs[i].fd);
            check($sformatf("vec%0d", i), vecs[i].e_push, vecs[i].e_pop, vecs[i].e_pv,
                  vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_svv, vecs[i].e_sv);
        end

        // held push key yields exactly one strobe
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'h99, 0, 0, 8'h00);
            if (push) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h00, 0, 0, 8'h00);
            if (push) pulses++;
        end
        check_val("hold_push_pulses", pulses, 1);
        check("hold_push_final", 0, 0, 8'h00, 4, 1, 1, 1, 8'hA5);

        // reset while in WAIT, push key held through release
        step(0, 1, 8'h00, 0, 0, 8'h00);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        check("wait_pop", 0, 1, 8'h00, 3, 1, 1, 1, 8'hA5);
        push_key  = 1'b1;
        data_in   = 8'hC3;
        fifo_data = 8'h5A;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_in_wait", 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 8'hC3, 0, 0, 8'h5A);
        check("rel_edge1", 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        step(1, 0, 8'hC3, 0, 0, 8'h5A);
        check("rel_edge2", 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        step(1, 0, 8'hC3, 0, 0, 8'h5A);
        check("rel_edge3_push", 1, 0, 8'hC3, 1, 0, 0, 0, 8'h00);
        step(1, 0, 8'hC3, 0, 0, 8'h5A);
        check("rel_edge4", 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);

        // pop while empty after reset
        step(0, 1, 8'h00, 1, 0, 8'h00);
        step(0, 0, 8'h00, 1, 0, 8'h00);
        step(0, 0, 8'h00, 1, 0, 8'h00);
        check("pop_empty", 0, 0, 8'h00, 1, 0, 1, 0, 8'h00);
        step(0, 0, 8'h00, 0, 0, 8'h00);
        check("pop_empty_after", 0, 0, 8'h00, 1, 0, 1, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected end by 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_key_ctrl.md
# fifo_key_ctrl

Front-end controller for the lab FIFO buffer. It turns raw, asynchronous push/pop key levels into clean single-cycle `push`/`pop` strobes and registers the value to be written. It blocks illegal operations using the FIFO's `full`/`empty` flags, records overflow and underflow attempts, and tracks occupancy. It sits directly upstream of the FIFO on the write/request side and captures the FIFO's popped data for display downstream.

## Interface
Parameters:
- depth, 4, FIFO address bits; capacity is 2**depth entries
- width, 8, data word width

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- push_key  in  1  raw push request level (asynchronous, active-high)
- pop_key  in  1  raw pop request level (asynchronous, active-high)
- data_in  in  width  value to enqueue (switches), sampled when a push is issued
- empty  in  1  FIFO empty flag
- full  in  1  FIFO full flag
- fifo_data  in  width  FIFO read data, valid the cycle after `pop`
- push  out  1  registered single-cycle write strobe to FIFO
- pop  out  1  registered single-cycle read strobe to FIFO
- pushedValue  out  width  registered write data, valid while `push`=1
- shown_value  out  width  last value popped
- shown_valid  out  1  high once any value has been captured
- count  out  depth+1  occupancy as tracked by issued strobes
- overflow  out  1  sticky: push request arrived while full
- underflow  out  1  sticky: pop request arrived while empty

## Operation
- Each key passes through a 2-flop synchronizer and a previous-value register. A request is the rising edge of the synchronized level (sync2 & !prev). Holding a key produces exactly one request.
- Push request:
  - If `full`=0: assert `push` for one cycle, load `pushedValue` <= data_in, count += 1.
  - If `full`=1: no strobe, set `overflow`.
- Pop request, handled by a 2-state FSM:
  - IDLE: a pop request with `empty`=0 asserts `pop` for one cycle, count -= 1, then go to WAIT. A pop request with `empty`=1 sets `underflow` and stays in IDLE.
  - WAIT: `shown_value` <= fifo_data, `shown_valid` <= 1, return to IDLE. A pop request arriving in WAIT is dropped: no strobe, no flag.
- Push and pop requests in the same cycle in IDLE:
  - Each is evaluated independently against the current flags. Both may issue, and count is then unchanged.
  - If `empty`=1, only the push issues and `underflow` is set.
  - If `full`=1, only the pop issues and `overflow` is set.
- Push requests are serviced in any FSM state.
- `count` never exceeds 2**depth and never goes below 0, because strobes are gated by the flags.
- `overflow`/`underflow` clear only on reset.

## Timing
- Reset values:
  - Outputs: push=0, pop=0, pushedValue=0, shown_value=0, shown_valid=0, count=0, overflow=0, underflow=0.
  - Internal: FSM=IDLE, sync/prev flops=0.
- Key to strobe latency: a key first sampled high at edge k gives `push`/`pop` high in the cycle after edge k+2, for exactly one cycle.
- Minimum spacing between accepted requests of the same key is 2 cycles (one low sample plus one high sample).
- Pop to display: `pop` high in cycle n, and `shown_value` updates at the end of cycle n+1 (visible in cycle n+2).
- Flags are evaluated in the cycle the request is detected. Flag updates from the FIFO caused by a strobe are not seen until the following cycle.
- Reset asserted mid-operation, including in WAIT: a pending capture is discarded and all outputs return to reset values asynchronously.
- A key held high through reset release produces one request 3 edges after release.

## Test plan
- Reset, then push_key pulses with data_in=8'h11, 8'h22, 8'h33 and empty/full low -> three single-cycle `push` pulses, each 3 edges after its key, with pushedValue 11/22/33; count=3.
- Hold push_key high for 20 cycles -> exactly one `push`; count increments by 1.
- Drive full=1, pulse push_key -> no `push`, overflow=1 and it stays 1; count unchanged.
- Drive empty=1, pulse pop_key -> no `pop`, underflow=1. Then empty=0, pop_key pulse, fifo_data=8'hA5 in the cycle after `pop` -> shown_value=A5, shown_valid=1, count decrements.
- Simultaneous push_key/pop_key edges with count=2 and flags low -> `push` and `pop` in the same cycle, count stays 2. Repeat with empty=1 -> only `push` issues, underflow=1.
- Assert reset during WAIT with fifo_data=8'h5A -> shown_value stays 0, all outputs 0. With push_key held through release -> one `push` 3 edges after release.
